// File: rtl/mux_n_pipe.sv
// Pipeline-stage N:1 source select with a stall/flush register, a valid bit that
// travels with the data, and sticky illegal-select tracking.
module mux_n_pipe #(
    parameter int              WIDTH     = 32,
    parameter int              NUM_SRC   = 4,
    parameter int              SEL_W     = 3,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH*NUM_SRC-1:0] din,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         dout_comb,
    output logic                     sel_err,
    output logic [7:0]               err_cnt
);

    generate
        if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
            $error("mux_n_pipe: NUM_SRC must be in the range 2..8");
        end
        if ((1 << SEL_W) < NUM_SRC) begin : g_bad_sel_w
            $error("mux_n_pipe: SEL_W too narrow to address NUM_SRC sources");
        end
    endgenerate

    logic             sel_legal;
    logic [WIDTH-1:0] dout_comb_w;
    logic [WIDTH-1:0] dout_d,      dout_q;
    logic             out_valid_d, out_valid_q;
    logic             sel_err_d,   sel_err_q;
    logic [7:0]       err_cnt_d,   err_cnt_q;

    assign sel_legal = (int'(sel) < NUM_SRC);

    // Out-of-range codes fall back to source 0 so the forwarding compare never sees X.
    always_comb begin
        dout_comb_w = din[WIDTH-1:0];
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(sel) == k) begin
                dout_comb_w = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        err_cnt_d   = err_cnt_q;
        if (flush) begin
            dout_d      = FLUSH_VAL;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            dout_d      = dout_comb_w;
            out_valid_d = in_valid;
            // Bubbles carry don't-care selects, so only real instructions count.
            if (in_valid && !sel_legal) begin
                sel_err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q      <= FLUSH_VAL;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign dout_comb = dout_comb_w;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: a 5-source instance (illegal codes 5..7 exist) and a
// 2-source instance compared against the legacy 2:1 select plus register.
module tb_mux_n_pipe;

  localparam int W  = 32;
  localparam int NA = 5;
  localparam int SA = 3;
  localparam int NB = 2;
  localparam int SB = 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // instance A signals
  logic [W*NA-1:0] a_din = '0;
  logic [SA-1:0]   a_sel = '0;
  logic            a_in_valid = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
  logic [W-1:0]    a_dout, a_dout_comb;
  logic            a_out_valid, a_sel_err;
  logic [7:0]      a_err_cnt;

  // instance B signals
  logic [W*NB-1:0] b_din = '0;
  logic [SB-1:0]   b_sel = '0;
  logic            b_in_valid = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
  logic [W-1:0]    b_dout, b_dout_comb;
  logic            b_out_valid, b_sel_err;
  logic [7:0]      b_err_cnt;

  mux_n_pipe #(.WIDTH(W), .NUM_SRC(NA), .SEL_W(SA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .din(a_din), .sel(a_sel), .in_valid(a_in_valid),
    .stall(a_stall), .flush(a_flush), .dout(a_dout), .out_valid(a_out_valid),
    .dout_comb(a_dout_comb), .sel_err(a_sel_err), .err_cnt(a_err_cnt)
  );

  mux_n_pipe #(.WIDTH(W), .NUM_SRC(NB), .SEL_W(SB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .din(b_din), .sel(b_sel), .in_valid(b_in_valid),
    .stall(b_stall), .flush(b_flush), .dout(b_dout), .out_valid(b_out_valid),
    .dout_comb(b_dout_comb), .sel_err(b_sel_err), .err_cnt(b_err_cnt)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] src [NA];
  logic [W-1:0] exp_dout;
  logic         exp_valid;
  logic         exp_err;
  int           exp_cnt;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_pick(input int s);
    return (s < NA) ? src[s] : src[0];
  endfunction

  task automatic model_reset();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = 0;
  endtask

  task automatic check_a_regs(input string tag);
    check({tag, ".dout"},      a_dout,      exp_dout);
    check({tag, ".out_valid"}, a_out_valid, exp_valid);
    check({tag, ".sel_err"},   a_sel_err,   exp_err);
    check({tag, ".err_cnt"},   a_err_cnt,   exp_cnt[7:0]);
  endtask

  // Drive one cycle on instance A from src/sel/valid/stall/flush; inputs change
  // 1 time unit after a rising edge and outputs are sampled 1 unit later.
  task automatic step_a(input string tag, input int s, input bit v, input bit st, input bit fl);
    for (int k = 0; k < NA; k++) a_din[k*W +: W] = src[k];
    a_sel      = SA'(s);
    a_in_valid = v;
    a_stall    = st;
    a_flush    = fl;
    #1;
    check({tag, ".dout_comb"}, a_dout_comb, model_pick(s));
    @(posedge clk);
    if (fl) begin
      exp_dout  = '0;
      exp_valid = 1'b0;
    end else if (!st) begin
      exp_dout  = model_pick(s);
      exp_valid = v;
      if (v && s >= NA) begin
        exp_err = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
    #1;
    check_a_regs(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_a_regs(tag);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_base_sources();
    src[0] = 32'hA0; src[1] = 32'hB1; src[2] = 32'hC2; src[3] = 32'hD3; src[4] = 32'hE4;
  endtask

  logic [W-1:0] b_a, b_b, b_exp;
  logic         b_exp_v;

  initial begin
    model_reset();
    load_base_sources();
    repeat (2) @(posedge clk);
    #1;
    check_a_regs("por");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // capture a known value, then reset asynchronously mid-cycle
    src[1] = 32'h1234_5678;
    step_a("pre_rst", 1, 1'b1, 1'b0, 1'b0);
    async_reset("async_rst");

    load_base_sources();
    step_a("cap_sel2", 2, 1'b1, 1'b0, 1'b0);

    // stall hold while select and data churn
    step_a("cap_sel1", 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NA; k++) src[k] = $urandom;
      step_a("stall_hold", i, 1'b1, 1'b1, 1'b0);
      check("stall_hold_b1", a_dout, 32'hB1);
    end
    load_base_sources();
    step_a("stall_release", 3, 1'b1, 1'b0, 1'b0);
    check("release_d3", a_dout, 32'hD3);

    // flush beats stall
    step_a("flush_stall", 2, 1'b1, 1'b1, 1'b1);
    step_a("after_flush", 0, 1'b1, 1'b0, 1'b0);

    // illegal selects
    step_a("illegal_valid", 6, 1'b1, 1'b0, 1'b0);
    step_a("illegal_bubble", 7, 1'b0, 1'b0, 1'b0);
    step_a("illegal_stall", 6, 1'b1, 1'b1, 1'b0);
    step_a("illegal_flush", 5, 1'b1, 1'b0, 1'b1);

    // saturation
    for (int i = 0; i < 260; i++) begin
      step_a("saturate", $urandom_range(NA, 7), 1'b1, 1'b0, 1'b0);
    end
    check("sat_ff", a_err_cnt, 8'hFF);

    // reset during stall and flush clears everything
    a_stall = 1'b1;
    a_flush = 1'b1;
    async_reset("rst_over_stall_flush");
    a_stall = 1'b0;
    a_flush = 1'b0;

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NA; k++) src[k] = $urandom;
      step_a("random", $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
    end

    // legacy 2:1 equivalence on instance B
    for (int i = 0; i < 1000; i++) begin
      b_a        = $urandom;
      b_b        = $urandom;
      b_din      = {b_b, b_a};
      b_sel      = 1'($urandom_range(0, 1));
      b_in_valid = 1'($urandom_range(0, 1));
      b_exp      = b_sel ? b_b : b_a;
      b_exp_v    = b_in_valid;
      #1;
      check("legacy.dout_comb", b_dout_comb, b_exp);
      @(posedge clk);
      #1;
      check("legacy.dout", b_dout, b_exp);
      check("legacy.out_valid", b_out_valid, b_exp_v);
      check("legacy.sel_err", b_sel_err, 1'b0);
    end
    check("legacy.err_cnt", b_err_cnt, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised successor to the combinational 2:1 32-bit select used in the pipelined CPU datapath.
- Selects one of NUM_SRC data sources, each WIDTH bits, by a binary select, and registers the result as a pipeline-stage output.
- Supports stall (hold), flush (bubble insert), a valid bit that travels with the data, and a sticky error flag for illegal select codes.
- Sits at stage boundaries, e.g. the forwarding select feeding the ID/EX operand register.

Parameters:
- WIDTH, 32: data width of each source and of the output.
- NUM_SRC, 4: number of sources, 2..8.
- SEL_W, 3: select width; must satisfy 2^SEL_W >= NUM_SRC.
- FLUSH_VAL, 32'h0000_0000: value loaded into dout on flush and on reset.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- din, input, WIDTH*NUM_SRC: packed sources; source k occupies din[k*WIDTH +: WIDTH].
- sel, input, SEL_W: binary source select.
- in_valid, input, 1: the current selection carries a real instruction.
- stall, input, 1: hold the registered contents.
- flush, input, 1: replace the registered contents with a bubble.
- dout, output, WIDTH: registered selected data.
- out_valid, output, 1: registered valid bit.
- dout_comb, output, WIDTH: unregistered selected data, for same-cycle forwarding compare.
- sel_err, output, 1: sticky flag; an out-of-range select was captured.
- err_cnt, output, 8: saturating count of out-of-range captures.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately without a clock edge):
  - dout=FLUSH_VAL, out_valid=0, sel_err=0, err_cnt=0.
  - Reset asserted mid-stall or mid-flush overrides both.
- Combinational path:
  - dout_comb = source[sel] when sel < NUM_SRC.
  - Otherwise dout_comb = source 0 (safe default).
  - dout_comb has no dependence on stall or flush.
- Sequential path: one update per rising clk edge, evaluated in this priority order:
  1. flush=1: dout<=FLUSH_VAL, out_valid<=0. Flush beats stall when both are asserted.
  2. stall=1, flush=0: dout and out_valid hold their values.
  3. otherwise: dout<=dout_comb, out_valid<=in_valid.
- Latency:
  - dout and out_valid: exactly one cycle from din/sel/in_valid.
  - dout_comb: zero cycles.
- Error tracking:
  - A capture is an edge where case 3 applies.
  - On a capture with in_valid=1 and sel >= NUM_SRC: sel_err<=1 and err_cnt<=err_cnt+1, saturating at 8'hFF.
  - Illegal sel with in_valid=0 is ignored, because bubbles carry don't-care selects.
  - Illegal sel during a stall or flush is ignored.
  - sel_err clears only on reset.
- Boundary conditions:
  - NUM_SRC = 2^SEL_W: no illegal codes exist, so sel_err stays 0.
  - NUM_SRC=2: must behave as the 2:1 mux (sel=0→A, sel=1→B) plus the register.
  - A stall longer than one cycle holds indefinitely; din changes during the stall do not reach dout.
  - The first capture after the stall releases uses the inputs present on that edge.
- Elaboration check: NUM_SRC outside 2..8, or 2^SEL_W < NUM_SRC, is a parameter error; the design must not silently truncate.
- Everything outside the dout/out_valid/sel_err/err_cnt flops is combinational; no latches.

Test Plan:
- Reset and basic capture:
  - Stimulus: assert reset_n=0 asynchronously mid-cycle with dout=32'h1234_5678.
  - Required: dout=0 and out_valid=0 immediately.
  - Stimulus: release reset; sources = 32'hA0, 32'hB1, 32'hC2, 32'hD3; sel=2, in_valid=1.
  - Required: after 1 edge, dout=32'hC2 and out_valid=1; dout_comb=32'hC2 in the same cycle.
- Stall hold:
  - Stimulus: capture sel=1 (32'hB1); then stall=1 for 3 cycles while sel cycles 0..3 and din changes.
  - Required: dout stays 32'hB1 with out_valid=1 throughout.
  - Stimulus: drop stall with sel=3.
  - Required: next edge dout=32'hD3.
- Flush priority:
  - Stimulus: stall=1 and flush=1 on the same edge.
  - Required: dout=FLUSH_VAL, out_valid=0.
  - Stimulus: next edge flush=0, stall=0, sel=0.
  - Required: dout=32'hA0.
- Illegal select (NUM_SRC=5, SEL_W=3):
  - Stimulus: sel=6 with in_valid=1.
  - Required: dout=source 0, sel_err=1, err_cnt=1.
  - Stimulus: sel=7 with in_valid=0.
  - Required: err_cnt stays 1.
  - Stimulus: sel=6 with stall=1.
  - Required: err_cnt unchanged.
- Saturation:
  - Stimulus: 260 consecutive valid illegal-select captures.
  - Required: err_cnt=8'hFF, no wrap.
  - Stimulus: reset.
  - Required: err_cnt=0 and sel_err=0.
- Legacy equivalence (NUM_SRC=2, SEL_W=1):
  - Stimulus: random A, B, sel over 1000 cycles, no stall or flush.
  - Required: dout equals the previous cycle's (sel ? B : A) on every edge; sel_err stays 0.
